// File: rtl/slot_reel_if.sv
// slot_reel_if: result bus between the reel controller and the payout/display
// logic. The controller (master) presents the three reel symbols, the
// per-reel stop flags and the match flags under a valid/ready handshake.
// The consumer (slave) returns result_ready.
//   reel0..reel2  N-bit reel symbols (display and result)
//   stopped       bit k = reel k frozen
//   result_valid  reels final, triple/pair valid
//   result_ready  consumer accepts the result
//   triple, pair  match flags, only ever high with result_valid
interface slot_reel_if #(
    parameter int N = 3
);
    logic [N-1:0] reel0;
    logic [N-1:0] reel1;
    logic [N-1:0] reel2;
    logic [2:0]   stopped;
    logic         result_valid;
    logic         result_ready;
    logic         triple;
    logic         pair;

    modport master (
        output reel0, reel1, reel2, stopped, result_valid, triple, pair,
        input  result_ready
    );

    modport slave (
        input  reel0, reel1, reel2, stopped, result_valid, triple, pair,
        output result_ready
    );
endinterface

// File: rtl/slot_reel_ctrl.sv
// slot_reel_ctrl: turns a spin request into three reels that stop one after
// another, sampling the free-running RNG symbol stream. Once the last reel
// stops, the symbol triple and the match flags are held on the result bus
// until the consumer accepts them.
// Ports:
//   clk         clock
//   reset       synchronous, active-high; aborts any spin or hold
//   rng         current RNG symbol, may change every cycle
//   spin_start  spin request, only looked at in IDLE
//   credit_ok   qualifies spin_start
//   busy        high while spinning or holding a result
//   res         result bus (reels, stopped, valid/ready, triple, pair)
module slot_reel_ctrl #(
    parameter int N           = 3,
    parameter int SPIN_CYCLES = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   rng,
    input  logic           spin_start,
    input  logic           credit_ok,
    output logic           busy,
    slot_reel_if.master    res
);

    localparam int CW = (3 * SPIN_CYCLES > 1) ? $clog2(3 * SPIN_CYCLES) : 1;
    // cnt value sampled on the edge where each reel freezes
    localparam logic [CW-1:0] STOP0 = CW'(SPIN_CYCLES - 1);
    localparam logic [CW-1:0] STOP1 = CW'(2 * SPIN_CYCLES - 1);
    localparam logic [CW-1:0] STOP2 = CW'(3 * SPIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SPIN = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [CW-1:0]   cnt_r;
    logic [CW-1:0]   cnt_nxt_s;
    logic [N-1:0]    reel_r     [3];
    logic [N-1:0]    reel_nxt_s [3];
    logic [2:0]      stopped_r;
    logic [2:0]      stopped_nxt_s;
    logic            busy_r;
    logic            busy_nxt_s;
    logic            valid_r;
    logic            valid_nxt_s;
    logic            triple_r;
    logic            triple_nxt_s;
    logic            pair_r;
    logic            pair_nxt_s;
    logic [1:0]      flags_s;
    logic            accept_s;

    // {triple, pair} for a symbol triple; the two flags are mutually exclusive
    function automatic logic [1:0] match_flags(
        input logic [N-1:0] a,
        input logic [N-1:0] b,
        input logic [N-1:0] c
    );
        logic t;
        logic p;
        t = (a == b) && (b == c);
        p = !t && ((a == b) || (b == c) || (a == c));
        return {t, p};
    endfunction

    assign accept_s = spin_start & credit_ok;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_SPIN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SPIN: begin
                if (cnt_r == STOP2) begin
                    state_nxt_s = ST_HOLD;
                end else begin
                    state_nxt_s = ST_SPIN;
                end
            end
            ST_HOLD: begin
                // result_valid is always high in HOLD, so ready alone completes the transfer
                if (res.result_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_HOLD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the counter, reels and all registered outputs
    always_comb begin
        cnt_nxt_s     = cnt_r;
        stopped_nxt_s = stopped_r;
        busy_nxt_s    = busy_r;
        valid_nxt_s   = valid_r;
        triple_nxt_s  = triple_r;
        pair_nxt_s    = pair_r;
        flags_s       = 2'b00;
        for (int k = 0; k < 3; k++) begin
            reel_nxt_s[k] = reel_r[k];
        end
        case (state_r)
            ST_IDLE: begin
                // reels and stopped keep the last result until a spin is taken
                if (accept_s) begin
                    cnt_nxt_s     = '0;
                    stopped_nxt_s = 3'b000;
                    busy_nxt_s    = 1'b1;
                end else begin
                    busy_nxt_s    = 1'b0;
                end
            end
            ST_SPIN: begin
                // every reel that is still spinning follows rng, including on its stop edge
                for (int k = 0; k < 3; k++) begin
                    if (!stopped_r[k]) begin
                        reel_nxt_s[k] = rng;
                    end else begin
                        reel_nxt_s[k] = reel_r[k];
                    end
                end
                if (cnt_r == STOP0) begin
                    stopped_nxt_s[0] = 1'b1;
                end else if (cnt_r == STOP1) begin
                    stopped_nxt_s[1] = 1'b1;
                end else begin
                    stopped_nxt_s[1:0] = stopped_r[1:0];
                end
                if (cnt_r == STOP2) begin
                    // last reel stops: flags come from the values being registered now
                    stopped_nxt_s[2] = 1'b1;
                    valid_nxt_s      = 1'b1;
                    flags_s          = match_flags(reel_nxt_s[0], reel_nxt_s[1], reel_nxt_s[2]);
                    triple_nxt_s     = flags_s[1];
                    pair_nxt_s       = flags_s[0];
                    cnt_nxt_s        = cnt_r;
                end else begin
                    cnt_nxt_s        = cnt_r + CW'(1);
                end
            end
            ST_HOLD: begin
                if (res.result_ready) begin
                    busy_nxt_s   = 1'b0;
                    valid_nxt_s  = 1'b0;
                    triple_nxt_s = 1'b0;
                    pair_nxt_s   = 1'b0;
                end else begin
                    valid_nxt_s  = 1'b1;
                end
            end
            default: begin
                cnt_nxt_s     = '0;
                stopped_nxt_s = 3'b000;
                busy_nxt_s    = 1'b0;
                valid_nxt_s   = 1'b0;
                triple_nxt_s  = 1'b0;
                pair_nxt_s    = 1'b0;
            end
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r     <= '0;
            stopped_r <= 3'b000;
            busy_r    <= 1'b0;
            valid_r   <= 1'b0;
            triple_r  <= 1'b0;
            pair_r    <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                reel_r[k] <= '0;
            end
        end else begin
            cnt_r     <= cnt_nxt_s;
            stopped_r <= stopped_nxt_s;
            busy_r    <= busy_nxt_s;
            valid_r   <= valid_nxt_s;
            triple_r  <= triple_nxt_s;
            pair_r    <= pair_nxt_s;
            for (int k = 0; k < 3; k++) begin
                reel_r[k] <= reel_nxt_s[k];
            end
        end
    end

    assign busy             = busy_r;
    assign res.reel0        = reel_r[0];
    assign res.reel1        = reel_r[1];
    assign res.reel2        = reel_r[2];
    assign res.stopped      = stopped_r;
    assign res.result_valid = valid_r;
    assign res.triple       = triple_r;
    assign res.pair         = pair_r;

endmodule

// File: tb/tb_slot_reel_ctrl.sv
// Directed bench for slot_reel_ctrl with N=3, SPIN_CYCLES=4.
module tb_slot_reel_ctrl;

    localparam int N  = 3;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] rng;
    logic         spin_start;
    logic         credit_ok;
    logic         busy;

    slot_reel_if #(.N(N)) res ();

    slot_reel_ctrl #(.N(N), .SPIN_CYCLES(SC)) dut (
        .clk        (clk),
        .reset      (reset),
        .rng        (rng),
        .spin_start (spin_start),
        .credit_ok  (credit_ok),
        .busy       (busy),
        .res        (res.master)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    logic [2:0] exp_r0, exp_r1, exp_r2;
    logic [1:0] exp_f;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // {triple, pair} from the number of equal reel pairs
    function automatic logic [1:0] model_flags(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
        int n;
        n = int'(a == b) + int'(b == c) + int'(a == c);
        return {n == 3, n == 1};
    endfunction

    task automatic check_zero(input string tag);
        check_val(tag, {res.reel0, res.reel1, res.reel2, res.stopped, busy,
                        res.result_valid, res.triple, res.pair}, 32'h0);
    endtask

    // One full spin from IDLE; rng is cycle count mod 8 or three segments
    task automatic run_spin(input bit cyc_mode, input logic [2:0] r0, input logic [2:0] r1,
                            input logic [2:0] r2, input bit hammer);
        logic [2:0] cur;
        rng        = cyc_mode ? 3'(cyc % 8) : r0;
        spin_start = 1'b1;
        credit_ok  = 1'b1;
        step();
        spin_start = hammer;
        check_val("spin_busy", {29'd0, busy, res.result_valid, 1'b0}, 32'h4);
        check_val("spin_stopped0", {29'd0, res.stopped}, 32'h0);
        for (int k = 1; k <= 3 * SC; k++) begin
            cur = cyc_mode ? 3'(cyc % 8) : ((k <= SC) ? r0 : (k <= 2 * SC) ? r1 : r2);
            rng = cur;
            step();
            if (k == SC) begin
                exp_r0 = cur;
                check_val("reel0_stop", {29'd0, res.reel0}, {29'd0, exp_r0});
                check_val("stopped_001", {29'd0, res.stopped}, 32'h1);
            end
            if (k == SC + 1) begin
                check_val("reel1_lag", {29'd0, res.reel1}, {29'd0, cur});
            end
            if (k == 2 * SC) begin
                exp_r1 = cur;
                check_val("reel1_stop", {29'd0, res.reel1}, {29'd0, exp_r1});
                check_val("stopped_011", {29'd0, res.stopped}, 32'h3);
            end
            if (k == 3 * SC - 1) begin
                check_val("valid_early", {31'd0, res.result_valid}, 32'h0);
            end
            if (k == 3 * SC) begin
                exp_r2 = cur;
                exp_f  = model_flags(exp_r0, exp_r1, exp_r2);
                check_val("reel2_stop", {29'd0, res.reel2}, {29'd0, exp_r2});
                check_val("stopped_111", {29'd0, res.stopped}, 32'h7);
                check_val("valid_rise", {30'd0, res.result_valid, busy}, 32'h3);
                check_val("flags", {30'd0, res.triple, res.pair}, {30'd0, exp_f});
            end
        end
        spin_start = 1'b0;
    endtask

    task automatic release_result();
        res.result_ready = 1'b1;
        step();
        check_val("release", {30'd0, busy, res.result_valid}, 32'h0);
        res.result_ready = 1'b0;
    endtask

    initial begin
        // reset dominates random activity on the inputs
        reset = 1'b1; rng = 3'($urandom); spin_start = 1'b1; credit_ok = 1'b1;
        res.result_ready = 1'b1;
        step();
        rng = 3'($urandom);
        step();
        check_zero("reset");
        reset = 1'b0; spin_start = 1'b0; res.result_ready = 1'b0;
        step();
        check_zero("idle_after_reset");

        // basic spin, rng = cycle count mod 8
        run_spin(1'b1, 3'd0, 3'd0, 3'd0, 1'b0);

        // backpressure: result stable for 10 cycles, spin_start toggling
        for (int i = 0; i < 10; i++) begin
            rng = 3'($urandom);
            spin_start = i[0];
            step();
            check_val("hold_stable", {18'd0, busy, res.result_valid, res.reel0, res.reel1, res.reel2,
                                      res.stopped, res.triple, res.pair},
                      {18'd0, 1'b1, 1'b1, exp_r0, exp_r1, exp_r2, 3'b111, exp_f});
        end

        // ready together with spin_start: back to IDLE, spin not taken
        res.result_ready = 1'b1; spin_start = 1'b1;
        step();
        check_val("ready_with_spin", {26'd0, busy, res.result_valid, res.stopped, res.triple},
                  {26'd0, 1'b0, 1'b0, 3'b111, 1'b0});
        res.result_ready = 1'b0;

        // next cycle spin accepted; rng held at 5 and spin_start hammered during SPIN
        run_spin(1'b0, 3'd5, 3'd5, 3'd5, 1'b1);
        check_val("triple_555", {30'd0, res.triple, res.pair}, 32'h2);
        spin_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("spin_in_hold", {28'd0, busy, res.result_valid, res.triple, res.stopped[2]}, 32'hF);
        end
        spin_start = 1'b0;
        release_result();

        run_spin(1'b0, 3'd5, 3'd5, 3'd2, 1'b0);
        check_val("pair_552", {30'd0, res.triple, res.pair}, 32'h1);
        release_result();

        run_spin(1'b0, 3'd1, 3'd3, 3'd6, 1'b0);
        check_val("none_136", {30'd0, res.triple, res.pair}, 32'h0);
        release_result();

        // no credit: request ignored, last stopped pattern kept
        spin_start = 1'b1; credit_ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("no_credit", {28'd0, busy, res.stopped}, 32'h7);
        end
        spin_start = 1'b0; credit_ok = 1'b1;

        // reset at cnt=6 aborts the spin
        spin_start = 1'b1;
        step();
        spin_start = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check_val("mid_spin", {28'd0, busy, res.stopped}, 32'h9);
        reset = 1'b1;
        step();
        check_zero("mid_spin_reset");
        reset = 1'b0;

        // back-to-back with ready tied high: accept every 14 cycles, valid one cycle wide
        res.result_ready = 1'b1; spin_start = 1'b1; credit_ok = 1'b1;
        for (int i = 1; i <= 45; i++) begin
            rng = 3'($urandom);
            step();
            check_val("b2b_valid", {31'd0, res.result_valid},
                      {31'd0, (i >= 13) && ((i - 13) % 14 == 0)});
            check_val("b2b_busy", {31'd0, busy},
                      {31'd0, !((i >= 14) && ((i - 14) % 14 == 0))});
        end
        spin_start = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
